execute_muldiv: RTL
===================

// Module: execute_muldiv
//
// PURPOSE
//   Parametrised multi-cycle execute unit for the pipelined WISC core.
//   - Sits beside the single-cycle ALU in the execute stage.
//   - Performs unsigned multiply (low/high half), divide and remainder iteratively, one bit per cycle.
//   - Resolves operand forwarding from NFWD bypass sources.
//   - Stalls the pipeline through a valid/ready handshake until the result is consumed.
//
// PARAMETERS
//   WIDTH  16  operand/result width in bits (>=4)
//   NFWD   4   number of forwarding sources on fwData
//   SELW   3   width of fwSelA/fwSelB; must satisfy 2**SELW >= NFWD+1
//
// PORTS
//   clk        in   1           core clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   in_valid   in   1           decode presents an op
//   in_ready   out  1           unit can accept an op
//   op         in   2           00 MUL lo, 01 MUL hi, 10 DIV, 11 REM
//   inA        in   WIDTH       register-file operand A
//   inB        in   WIDTH       register-file operand B
//   fwSelA     in   SELW        0 = inA; k in 1..NFWD = fwData slice k-1
//   fwSelB     in   SELW        same encoding, for B
//   fwData     in   NFWD*WIDTH  bypass values; slice k = [k*WIDTH +: WIDTH]
//   flush      in   1           squash the in-flight op (branch mispredict)
//   out_valid  out  1           result available
//   out_ready  in   1           memory stage consumes the result
//   out_data   out  WIDTH       result
//   out_dz     out  1           divide-by-zero flag, qualified by out_valid
//   stall      out  1           high while an accepted op is not yet retired
//
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - state=IDLE; out_valid=0, out_data=0, out_dz=0, stall=0.
//   - in_ready=1 once rst_n deasserts.
//   Operand select:
//   - Combinational.
//   - A select value > NFWD selects inA/inB.
//   Accept:
//   - An op is accepted on a clock edge with in_valid & in_ready.
//   - Selected operands and op are latched on that edge.
//   - in_ready=1 only in IDLE.
//   States:
//   - IDLE -> MUL when a MUL op is accepted.
//   - IDLE -> DIV when a DIV/REM op is accepted and B!=0.
//   - IDLE -> DONE when a DIV/REM op is accepted and B==0.
//   - MUL/DIV -> DONE when the iteration count reaches WIDTH.
//   - DONE -> IDLE on out_ready.
//   Counter:
//   - Width $clog2(WIDTH+1).
//   - Cleared on accept; increments once per MUL/DIV cycle.
//   MUL:
//   - Shift-add over a 2*WIDTH product register.
//   - op 00 returns product[WIDTH-1:0]; op 01 returns product[2*WIDTH-1:WIDTH].
//   DIV:
//   - Restoring division.
//   - op 10 returns the quotient; op 11 returns the remainder.
//   - Remainder register is WIDTH+1 bits wide.
//   Latency:
//   - Accept edge +WIDTH edges to DONE; out_valid rises on that edge.
//   - Divide by zero: out_valid is high one edge after accept.
//   Divide by zero:
//   - out_dz=1.
//   - DIV returns all ones; REM returns the dividend.
//   - out_dz=0 for every other result.
//   Output:
//   - out_valid=1 only in DONE.
//   - out_data/out_dz are stable while out_valid=1 and out_ready=0.
//   - They are zeroed on the retire edge.
//   stall:
//   - Equals (state != IDLE).
//   - Back-to-back ops: a new op may be accepted at the earliest on the edge after retire.
//   flush:
//   - Highest priority in every state: next state is IDLE, out_valid=0, counter cleared.
//   - A simultaneous in_valid is ignored.
//   - Flush in DONE with out_ready=1: the result is dropped and no retire is counted.
//   Reset mid-operation:
//   - Aborts immediately; no partial result is ever presented.
//   Width:
//   - All arithmetic is unsigned; no overflow flag.
//
// TESTING
//   - Reset: assert rst_n=0 mid-MUL -> out_valid=0 and stall=0 at once; in_ready=1 after release.
//   - MUL: WIDTH=16, A=0x1234, B=0x0010, op 00 -> out_data=0x2340 at accept+16 edges;
//     op 01 -> 0x0001; out_dz=0.
//   - DIV/REM: A=100, B=7 -> op 10 gives 14, op 11 gives 2.
//     Hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout.
//   - Divide by zero: A=0xBEEF, B=0 -> out_valid one edge after accept, out_dz=1;
//     DIV gives 0xFFFF, REM gives 0xBEEF.
//   - Forwarding: fwSelA=2, fwData slice1=0x0003; fwSelB=0, inB=0x0005; MUL lo -> 0x000F.
//     Select value NFWD+1 -> inA is used.
//   - Flush: flush at iteration 8 of a DIV, with in_valid=1 on the same edge -> IDLE next cycle,
//     no out_valid, and the new op is not accepted; a following op completes normally.

Source files
------------

// File: rtl/execute_muldiv_if.sv
// Handshake and operand bus between decode, the multi-cycle execute unit and the memory stage.
// The master side presents ops and consumes results; the unit itself is the slave.
interface execute_muldiv_if #(
   parameter int WIDTH = 16,
   parameter int NFWD  = 4,
   parameter int SELW  = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            op;
   logic [WIDTH-1:0]      inA;
   logic [WIDTH-1:0]      inB;
   logic [SELW-1:0]       fwSelA;
   logic [SELW-1:0]       fwSelB;
   logic [NFWD*WIDTH-1:0] fwData;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_dz;
   logic                  stall;

   modport master (
      output in_valid, op, inA, inB, fwSelA, fwSelB, fwData, flush, out_ready,
      input  in_ready, out_valid, out_data, out_dz, stall
   );

   modport slave (
      input  in_valid, op, inA, inB, fwSelA, fwSelB, fwData, flush, out_ready,
      output in_ready, out_valid, out_data, out_dz, stall
   );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative unsigned multiply/divide unit beside the execute-stage ALU.
// One bit per cycle; the result is held until the memory stage takes it.
module execute_muldiv #(
   parameter int WIDTH = 16,
   parameter int NFWD  = 4,
   parameter int SELW  = 3
) (
   input logic             clk,
   input logic             rst_n,
   execute_muldiv_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
   typedef enum logic [1:0] {OP_MULLO, OP_MULHI, OP_DIV, OP_REM} op_e;

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [2*WIDTH-1:0] prod_q, prod_d, mul_next;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH:0]     rem_q, rem_d, div_diff, rem_next;
   logic [WIDTH+1:0]   div_full;
   logic               div_fits;
   logic [WIDTH-1:0]   quo_q, quo_d, quo_next;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   sel_a, sel_b;
   logic               last;

   // Select 0 and anything above NFWD fall back to the register-file operand.
   function automatic logic [WIDTH-1:0] fwd_pick(input logic [SELW-1:0]       sel,
                                                 input logic [WIDTH-1:0]      rf,
                                                 input logic [NFWD*WIDTH-1:0] fw);
      fwd_pick = rf;
      for (int k = 1; k <= NFWD; k++) begin
         if (sel == SELW'(k)) fwd_pick = fw[(k-1)*WIDTH +: WIDTH];
      end
   endfunction

   assign sel_a = fwd_pick(bus.fwSelA, bus.inA, bus.fwData);
   assign sel_b = fwd_pick(bus.fwSelB, bus.inB, bus.fwData);

   assign cnt_inc = cnt_q + CW'(1);
   assign last    = (cnt_inc == CW'(WIDTH));

   // Shift-add: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
   assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

   // Restoring division: dividend bits shift out of quo_q into the remainder.
   assign div_full = {rem_q, quo_q[WIDTH-1]};
   assign div_fits = (div_full >= {2'b00, opb_q});
   assign div_diff = div_full[WIDTH:0] - {1'b0, opb_q};
   assign rem_next = div_fits ? div_diff : div_full[WIDTH:0];
   assign quo_next = {quo_q[WIDTH-2:0], div_fits};

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.stall     = (state_q != IDLE);
   assign bus.out_data  = res_q;
   assign bus.out_dz    = dz_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      opb_d   = opb_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      res_d   = res_q;
      dz_d    = dz_q;

      if (bus.flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         res_d   = '0;
         dz_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (bus.in_valid) begin
               op_d   = op_e'(bus.op);
               cnt_d  = '0;
               prod_d = {{WIDTH{1'b0}}, sel_b};
               quo_d  = sel_a;
               rem_d  = '0;
               opb_d  = bus.op[1] ? sel_b : sel_a;
               if (!bus.op[1]) begin
                  state_d = MUL;
               end else if (sel_b == '0) begin
                  state_d = DONE;
                  dz_d    = 1'b1;
                  res_d   = (op_e'(bus.op) == OP_DIV) ? '1 : sel_a;
               end else begin
                  state_d = DIV;
               end
            end
            MUL: begin
               prod_d = mul_next;
               cnt_d  = cnt_inc;
               if (last) begin
                  state_d = DONE;
                  res_d   = (op_q == OP_MULHI) ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
               end
            end
            DIV: begin
               rem_d = rem_next;
               quo_d = quo_next;
               cnt_d = cnt_inc;
               if (last) begin
                  state_d = DONE;
                  res_d   = (op_q == OP_REM) ? rem_next[WIDTH-1:0] : quo_next;
               end
            end
            DONE: if (bus.out_ready) begin
               state_d = IDLE;
               res_d   = '0;
               dz_d    = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments; the datapath is small, so it is reset too.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_MULLO;
         cnt_q   <= '0;
         prod_q  <= '0;
         opb_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         opb_q   <= opb_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
         dz_q    <= dz_d;
      end
   end
endmodule
